multicycle_controller: RTL

Parametrised multi-cycle control unit for the MIPS datapath: accepts one opcode per instruction over a valid/ready handshake and sequences it through DECODE, EXEC, optional MUL_WAIT/MEM, and WB states. It drives the register-file, ALU-source, memory and branch controls state by state, not purely from the opcode. It waits on a variable-latency data memory with a timeout and holds off new instructions during multiply latency. Sits between instruction fetch and the datapath, replacing the single-cycle opcode decoder.

---
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences one latched opcode at a time through
// DECODE/EXEC/(MUL_WAIT|MEM)/WB and drives the datapath controls per state.
module multicycle_controller #(
    parameter int unsigned MUL_LATENCY  = 4,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    input  logic [5:0]              opcode,
    output logic                    instr_ready,
    input  logic                    mem_ready,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic                    branch,
    output logic                    branch_ne,
    output logic                    mem_to_reg,
    output logic                    sign_ext,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    busy,
    output logic                    error
);

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StMulWait, StMem, StWb} state_e;
    typedef enum logic [2:0] {ClsAlu, ClsMul, ClsLoad, ClsStore, ClsBranch, ClsIllegal} class_e;

    localparam int unsigned MulLast = (MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0;
    localparam int unsigned MemLast = (MEM_TIMEOUT >= 1) ? MEM_TIMEOUT - 1 : 0;
    localparam int unsigned MulCntW = (MulLast >= 1) ? $clog2(MulLast + 1) : 1;
    localparam int unsigned MemCntW = (MemLast >= 1) ? $clog2(MemLast + 1) : 1;

    state_e               state_q, state_d;
    logic [5:0]           opcode_q;
    logic [MulCntW-1:0]   mul_cnt_q, mul_cnt_d;
    logic [MemCntW-1:0]   mem_cnt_q, mem_cnt_d;
    logic                 tmo_q, tmo_d;

    class_e     cls;
    logic [3:0] dec_alu;
    logic       dec_sext, dec_src, dec_dst;

    // Class decode works only on the latched opcode, never the live bus.
    always_comb begin
        cls      = ClsAlu;
        dec_alu  = 4'b0001;
        dec_sext = 1'b0;
        dec_src  = 1'b0;
        dec_dst  = 1'b0;
        case (opcode_q)
            6'b000000: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0000, 3'b100};
            6'b011111: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0000, 3'b011};
            6'b011100: begin
                {dec_alu, dec_sext, dec_src, dec_dst} = {4'b1100, 3'b100};
                cls = ClsMul;
            end
            6'b001001: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0111, 3'b011};
            6'b001000: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0001, 3'b111};
            6'b001100: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0100, 3'b011};
            6'b001101: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0011, 3'b011};
            6'b001110: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0101, 3'b011};
            6'b001010: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b1010, 3'b111};
            6'b001011: {dec_alu, dec_sext, dec_src, dec_dst} = {4'b1011, 3'b111};
            6'b100011: begin
                {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0001, 3'b111};
                cls = ClsLoad;
            end
            6'b101011: begin
                {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0001, 3'b111};
                cls = ClsStore;
            end
            6'b000100, 6'b000101: begin
                {dec_alu, dec_sext, dec_src, dec_dst} = {4'b0010, 3'b100};
                cls = ClsBranch;
            end
            default: cls = ClsIllegal;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        tmo_d       = 1'b0;
        instr_ready = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        mem_to_reg  = 1'b0;
        sign_ext    = 1'b0;
        alu_op      = ALU_OP_WIDTH'(4'b0001);
        busy        = (state_q != StIdle);
        error       = tmo_q;

        if (state_q != StIdle) begin
            alu_op   = ALU_OP_WIDTH'(dec_alu);
            alu_src  = dec_src;
            sign_ext = dec_sext;
            reg_dst  = dec_dst;
        end

        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StDecode;
            end
            StDecode: begin
                if (cls == ClsIllegal) begin
                    error   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls)
                    ClsMul:             state_d = (MUL_LATENCY > 1) ? StMulWait : StWb;
                    ClsLoad, ClsStore:  state_d = StMem;
                    ClsBranch: begin
                        branch    = 1'b1;
                        branch_ne = (opcode_q == 6'b000101);
                        state_d   = StIdle;
                    end
                    default:            state_d = StWb;
                endcase
            end
            StMulWait: begin
                if (mul_cnt_q == MulCntW'(MulLast)) begin
                    mul_cnt_d = '0;
                    state_d   = StWb;
                end else begin
                    mul_cnt_d = mul_cnt_q + MulCntW'(1);
                end
            end
            StMem: begin
                mem_read  = (cls == ClsLoad);
                mem_write = (cls == ClsStore);
                // A ready response on the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    mem_cnt_d = '0;
                    state_d   = (cls == ClsLoad) ? StWb : StIdle;
                end else if (MEM_TIMEOUT != 0 && mem_cnt_q == MemCntW'(MemLast)) begin
                    mem_cnt_d = '0;
                    tmo_d     = 1'b1;
                    state_d   = StIdle;
                end else begin
                    mem_cnt_d = mem_cnt_q + MemCntW'(1);
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == ClsLoad);
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            mul_cnt_q <= '0;
            mem_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            mem_cnt_q <= mem_cnt_d;
            tmo_q     <= tmo_d;
            if (state_q == StIdle && instr_valid) opcode_q <= opcode;
        end
    end

endmodule
